// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory-controller request interface.
// One transaction outstanding at a time; completions route to the owner; a watchdog frees a stuck bus.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_data_in,
  input  logic                  p0_r_en,
  input  logic                  p0_w_en,
  output logic                  p0_rdy,
  output logic                  p0_cplt,
  output logic [DATA_WIDTH-1:0] p0_data_out,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_data_in,
  input  logic                  p1_r_en,
  input  logic                  p1_w_en,
  output logic                  p1_rdy,
  output logic                  p1_cplt,
  output logic [DATA_WIDTH-1:0] p1_data_out,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  input  logic                  mem_rdy,
  input  logic                  mem_cplt,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  logic p0_req, p1_req, any_req, sel, accept, wd_fire, done;

  always_comb begin
    p0_req  = p0_r_en | p0_w_en;
    p1_req  = p1_r_en | p1_w_en;
    any_req = p0_req | p1_req;
    // Ties go to the port that did not win last; a lone requester always wins.
    if (p0_req && p1_req) begin
      sel = ~last_grant_q;
    end else begin
      sel = p1_req;
    end
    accept  = (state_q == IDLE) && any_req && mem_rdy;
    wd_fire = (state_q == BUSY) && !mem_cplt && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    done    = (state_q == BUSY) && (mem_cplt || wd_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wd_cnt_d     = wd_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = BUSY;
          owner_d      = sel;
          last_grant_d = sel;
          wd_cnt_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (done) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    mem_r_en    = 1'b0;
    mem_w_en    = 1'b0;
    p0_rdy      = 1'b0;
    p1_rdy      = 1'b0;
    p0_cplt     = 1'b0;
    p1_cplt     = 1'b0;
    p0_data_out = '0;
    p1_data_out = '0;
    timeout     = wd_fire;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          mem_addr    = sel ? p1_addr    : p0_addr;
          mem_data_in = sel ? p1_data_in : p0_data_in;
          mem_r_en    = sel ? p1_r_en    : p0_r_en;
          // A simultaneous read and write on one port forwards only the read.
          mem_w_en    = sel ? (p1_w_en & ~p1_r_en) : (p0_w_en & ~p0_r_en);
          p0_rdy      = mem_rdy & ~sel;
          p1_rdy      = mem_rdy & sel;
        end else begin
          mem_addr = '0;
        end
      end
      BUSY: begin
        // Watchdog completion carries zero data; a real completion carries controller data.
        if (owner_q) begin
          p1_cplt     = done;
          p1_data_out = mem_cplt ? mem_data_out : '0;
        end else begin
          p0_cplt     = done;
          p0_data_out = mem_cplt ? mem_data_out : '0;
        end
      end
      default: timeout = 1'b0;
    endcase
  end

endmodule
